// File: rtl/led_pwm_ctrl.sv
//==============================================================================
// Module : led_pwm_ctrl
// Brief  : 8-register LED bank slave with individual PWM, group dim and group blink.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module led_pwm_ctrl #(
    parameter int PRESCALE  = 64,
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sleep,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 r_en,
    input  logic                 w_en,
    inout  wire  [DATA_BITS-1:0] data,
    output logic [3:0]           led
);

    localparam int NREG  = 1 << ADDR_BITS;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(PRESCALE - 1);

    localparam int c_REG_MODE    = 0;
    localparam int c_REG_PWM0    = 1;
    localparam int c_REG_GRPPWM  = 5;
    localparam int c_REG_GRPFREQ = 6;
    localparam int c_REG_LEDOUT  = 7;

    localparam int c_MODE_SLEEP  = 0;
    localparam int c_MODE_BLINK  = 1;
    localparam int c_MODE_INVERT = 2;

    localparam logic [1:0] c_LED_OFF        = 2'b00;
    localparam logic [1:0] c_LED_ON         = 2'b01;
    localparam logic [1:0] c_LED_INDIVIDUAL = 2'b10;
    localparam logic [1:0] c_LED_GROUP      = 2'b11;

    logic [DATA_BITS-1:0] r_regs [NREG];
    logic [7:0]           r_sh_pwm [4];
    logic [7:0]           r_sh_grppwm;
    logic [PRE_W-1:0]     r_pre_cnt;
    logic [7:0]           r_pwm_cnt;
    logic [2:0]           r_grp_cnt;
    logic [13:0]          r_blink_cnt;
    logic [3:0]           r_led;

    logic [7:0]  w_mode;
    logic [7:0]  w_ledout;
    logic        w_slp;
    logic        w_tick;
    logic        w_pwm_wrap;
    logic [8:0]  w_period;
    logic [14:0] w_blink_last;
    logic [15:0] w_prod;
    logic [13:0] w_thr;
    logic [7:0]  w_dim_cnt;
    logic        w_grp_on;
    logic [3:0]  w_ind;
    logic [3:0]  w_raw;

    assign w_mode   = r_regs[c_REG_MODE];
    assign w_ledout = r_regs[c_REG_LEDOUT];
    assign w_slp    = sleep | w_mode[c_MODE_SLEEP];

    assign w_tick     = ~w_slp & (r_pre_cnt == c_PRE_MAX);
    assign w_pwm_wrap = w_tick & (r_pwm_cnt == 8'hFF);

    // Blink period tracks the live GRPFREQ so a shrinking period wraps early.
    assign w_period     = {1'b0, r_regs[c_REG_GRPFREQ]} + 9'd1;
    assign w_blink_last = {w_period, 6'b0} - 15'd1;
    assign w_prod       = 16'(w_period) * 16'(r_sh_grppwm);
    assign w_thr        = 14'(w_prod >> 2);

    assign w_dim_cnt = {r_grp_cnt, r_pwm_cnt[7:3]};
    assign w_grp_on  = w_mode[c_MODE_BLINK] ? (r_blink_cnt < w_thr)
                                            : (w_dim_cnt < r_sh_grppwm);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_led
            assign w_ind[gi] = (r_pwm_cnt < r_sh_pwm[gi]);

            always_comb begin
                w_raw[gi] = 1'b0;
                case (w_ledout[2*gi +: 2])
                    c_LED_OFF:        w_raw[gi] = 1'b0;
                    c_LED_ON:         w_raw[gi] = 1'b1;
                    c_LED_INDIVIDUAL: w_raw[gi] = w_ind[gi];
                    c_LED_GROUP:      w_raw[gi] = w_ind[gi] & w_grp_on;
                    default:          w_raw[gi] = 1'b0;
                endcase
                if (w_slp) begin
                    w_raw[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Bus is released immediately on reset, not at the next edge.
    assign data = (r_en && !w_en && !reset) ? r_regs[addr] : {DATA_BITS{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_en) begin
            r_regs[addr] <= data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt   <= '0;
            r_pwm_cnt   <= '0;
            r_grp_cnt   <= '0;
            r_blink_cnt <= '0;
        end else if (w_slp) begin
            r_pre_cnt   <= '0;
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
            if (w_pwm_wrap) begin
                r_grp_cnt   <= r_grp_cnt + 3'd1;
                r_blink_cnt <= ({1'b0, r_blink_cnt} >= w_blink_last) ? 14'd0
                                                                     : r_blink_cnt + 14'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_sh_pwm[i] <= '0;
            end
            r_sh_grppwm <= '0;
        end else if (w_slp || w_pwm_wrap) begin
            for (int i = 0; i < 4; i++) begin
                r_sh_pwm[i] <= r_regs[c_REG_PWM0 + i];
            end
            r_sh_grppwm <= r_regs[c_REG_GRPPWM];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_raw ^ {4{w_mode[c_MODE_INVERT]}};
        end
    end

    assign led = r_led;

endmodule

`default_nettype wire

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Bus-slave end of `bus_if` (`led_ctrl` side), sitting directly downstream of the I2C controller.
- Holds the 8-entry register bank indexed by `reg_enum_t` and serves reads and writes on the shared data bus.
- Generates the four LED outputs: off, on, individual PWM, group dim or group blink.
- Drives the LED pads directly.

Parameters:
- `PRESCALE`, 64: clk cycles per PWM step (25.6 MHz clk -> 400 kHz step -> 1.5625 kHz individual PWM).
- `ADDR_BITS`, 3: register address width, from `led_driver_pkg`.
- `DATA_BITS`, 8: register data width, from `led_driver_pkg`.

Ports:
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `sleep` input 1: global sleep from `global_if`.
- `addr` input `ADDR_BITS`: register select (`reg_enum_t`).
- `r_en` input 1: read strobe.
- `w_en` input 1: write strobe.
- `data` inout `DATA_BITS`: shared bus, driven by this block only during reads.
- `led` output 4: LED pad outputs, bit i = LEDi.

Behaviour:
- Reset: all 8 registers = 0x00; shadow PWM regs = 0; all counters = 0; `led` = 4'b0000; `data` = Z.
- Write: `w_en`=1 at a clk edge -> `reg[addr]` <= `data`. All bits are stored, including `auto_increment`, `output_change` and `reserved`, which have no further effect here.
- Read: `r_en`=1 and `w_en`=0 -> `data` = `reg[addr]` combinationally, same cycle. Otherwise `data` = Z.
- `r_en` and `w_en` both 1: the write is performed and `data` stays Z.
- Registers remain readable and writable during sleep.
- Effective sleep `slp` = `sleep` | `REG_MODE.sleep`.
  - While `slp`=1, prescaler, `pwm_cnt` and `blink_cnt` are held at 0, and the raw LED value = 0.
  - On exit from `slp`, counting resumes from 0.
- Prescaler `pre_cnt` counts 0..`PRESCALE`-1; `tick` = (`pre_cnt` == `PRESCALE`-1).
- `pwm_cnt` (8 bit) increments on `tick` and wraps 255 -> 0. `pwm_wrap` = `tick` & `pwm_cnt`==255.
- Shadow `PWM0..3` and `GRPPWM` load from the registers on `pwm_wrap` or while `slp`.
  - Duty changes therefore take effect only at an individual-period boundary; no mid-period glitch.
  - `LEDOUT` and `MODE` bits apply immediately.
- Individual compare: `ind_i` = (`pwm_cnt` < `shPWMi`). Duty 0 -> always off; 255 -> on 255 of 256 steps.
- Group dim (`MODE.dim_blink`=0):
  - 3-bit `grp_cnt` increments on `pwm_wrap`.
  - `dim_cnt` = {`grp_cnt`, `pwm_cnt`[7:3]}, 8 bit, giving about 195 Hz.
  - `grp_on` = (`dim_cnt` < `shGRPPWM`).
- Group blink (`MODE.dim_blink`=1):
  - 14-bit `blink_cnt` increments on `pwm_wrap`.
  - Period P = (`GRPFREQ`+1)*64 individual periods, giving 24.4 Hz down to 0.095 Hz.
  - At `pwm_wrap`, if `blink_cnt` >= P-1 then `blink_cnt` <= 0.
  - A new `GRPFREQ` below the current count therefore wraps at the next `pwm_wrap`.
  - On-threshold T = ((`GRPFREQ`+1)*`GRPPWM`) >> 2, with a 16-bit product truncated to 14 bits.
  - `grp_on` = (`blink_cnt` < T).
- Per-LED raw value from the `LEDOUT` field:
  - `LED_OFF` -> 0.
  - `LED_ON` -> 1.
  - `LED_INDIVIDUAL` -> `ind_i`.
  - `LED_GROUP` -> `ind_i` & `grp_on`.
- Output: `led[i]` <= raw_i ^ `MODE.invert`, registered, 1 clk after the compare.
  - During sleep, `led` = {4{`invert`}}.
- Counters `grp_cnt` and `blink_cnt` keep running across dim/blink switches; no reset on mode change.
- Reset asserted mid-operation: outputs clear asynchronously and immediately, and `data` releases to Z.

Test Plan:
1. Reset, then read all 8 addresses -> `data`=0x00 each, `led`=0000. Write 0xA5 to addr 3, read back -> 0xA5. With `w_en`=`r_en`=1, `data` stays Z.
2. `LEDOUT`=0x02 (LED0 individual), `PWM0`=0x40, `PRESCALE`=4 -> `led[0]` high 64 of every 256 steps (256 clk high / 1024 clk period). Write `PWM0`=0x80 mid-period -> old duty persists until `pwm_wrap`, then 128/256.
3. `LEDOUT`=0x03, `PWM0`=0xFF, `GRPPWM`=0x80, dim mode -> `led[0]` active during the first 4 of 8 individual periods, about 50% at 195 Hz.
4. Blink: `dim_blink`=1, `GRPFREQ`=1, `GRPPWM`=0x40, `PWM0`=0xFF -> P=128 periods, T=32. `led[0]` pulses during periods 0-31 and is low for 32-127. Write `GRPFREQ`=0 when `blink_cnt`=100 -> wraps to 0 at the next `pwm_wrap`.
5. `LEDOUT`=0x55 (all on), `invert`=1 -> `led`=0000. Set `MODE.sleep`=1 -> `led`=1111 and counters held at 0. Assert `sleep` pin with `MODE.sleep`=0 -> same result.
6. Assert `reset` mid-blink with `r_en` active -> `led`=0000 and `data`=Z without waiting for a clk edge. Registers read 0x00 after release.
